// File: rtl/lifo_access_arbiter.sv
// ---------------------------------------------------------------------------
// lifo_access_arbiter
//
// Shares one LIFO memory between NUM_REQ requesters. A winner is chosen
// among the active requests and is checked against the LIFO status flags.
// The block then issues a single-cycle PUSH or POP strobe, or rejects the
// request outright. Only one transaction is in flight at a time.
//
// Parameters:
//   DATA_WIDTH  word width, must match the attached LIFO
//   NUM_REQ     number of requesters (2..8)
//
// Ports:
//   Clk, Rst_n   clock (rising edge), asynchronous active-low reset
//   req/op/wdata per-requester request, op (1=push, 0=pop), push data
//   ack          one-hot completion pulse
//   err          valid with ack, 1 = rejected (push on full / pop on empty)
//   rdata        popped word, updated only by a successful pop
//   busy         high whenever the sequencer is not idle
//   lifo_push/lifo_pop/lifo_din   registered LIFO control pins
//   lifo_dout/lifo_empty/lifo_full LIFO read data and status pins
//
// Build option:
//   LIFO_ARB_FIXED_PRIO_EN  when defined, the lowest active index always wins
//                           and no grant history is kept; otherwise the
//                           arbitration is round-robin.
// ---------------------------------------------------------------------------
module lifo_access_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          err,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic                          lifo_push,
    output logic                          lifo_pop,
    output logic [DATA_WIDTH-1:0]         lifo_din,
    input  logic [DATA_WIDTH-1:0]         lifo_dout,
    input  logic                          lifo_empty,
    input  logic                          lifo_full
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   win_idx;
    logic            win_op;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;

    // Per-requester view of the packed push data bus.
    logic [DATA_WIDTH-1:0] word [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign word[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

`ifdef LIFO_ARB_FIXED_PRIO_EN
    // Lowest active index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] last_grant;
    logic [IW-1:0] cand;

    // Modulo-NUM_REQ increment that also works for non-power-of-two counts.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Walk the requesters starting one past the previous winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = next_idx(last_grant);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    // History moves on every grant, rejected ones included, so a requester
    // that keeps hitting a full/empty stack cannot starve the others.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_grant <= IW'(NUM_REQ - 1);
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant_idx;
        end
    end
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            win_idx   <= '0;
            win_op    <= 1'b0;
            ack       <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            lifo_push <= 1'b0;
            lifo_pop  <= 1'b0;
            lifo_din  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        // Winner, op and data are captured here; later
                        // request-side changes cannot affect this transaction.
                        win_idx <= grant_idx;
                        win_op  <= op[grant_idx];
                        if (op[grant_idx] ? lifo_full : lifo_empty) begin
                            ack   <= onehot(grant_idx);
                            err   <= 1'b1;
                            state <= RESP;
                        end else begin
                            lifo_push <= op[grant_idx];
                            lifo_pop  <= ~op[grant_idx];
                            if (op[grant_idx]) begin
                                lifo_din <= word[grant_idx];
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    lifo_push <= 1'b0;
                    lifo_pop  <= 1'b0;
                    if (win_op) begin
                        ack   <= onehot(win_idx);
                        err   <= 1'b0;
                        state <= RESP;
                    end else begin
                        // LIFO read data appears the cycle after the POP edge.
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rdata <= lifo_dout;
                    ack   <= onehot(win_idx);
                    err   <= 1'b0;
                    state <= RESP;
                end
                RESP: begin
                    ack   <= '0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lifo_access_arbiter
//
// Drives lifo_access_arbiter with NUM_REQ=2, DATA_WIDTH=8 against a simple
// behavioural 16-deep LIFO. Directed table vectors, hand-written multi-cycle
// sequences (contention, full, reset mid-pop) and a randomized phase checked
// each cycle against a transaction-level reference (stack queue + latency
// rules + round-robin pointer).
// ---------------------------------------------------------------------------
module tb_lifo_access_arbiter;

    localparam int NR    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     op = '0;
    logic [NR*DW-1:0]  wdata = '0;
    logic [NR-1:0]     ack;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic              lifo_push;
    logic              lifo_pop;
    logic [DW-1:0]     lifo_din;
    logic [DW-1:0]     lifo_dout;
    logic              lifo_empty;
    logic              lifo_full;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    lifo_access_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .req(req), .op(op), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_din(lifo_din),
        .lifo_dout(lifo_dout), .lifo_empty(lifo_empty), .lifo_full(lifo_full)
    );

    // Attached LIFO: registered read data, own clear independent of Rst_n.
    logic [DW-1:0] lmem [DEPTH];
    int            lcnt = 0;
    logic [DW-1:0] lout = '0;
    logic          lifo_clr = 1'b0;

    always @(posedge Clk) begin
        if (lifo_clr) begin
            lcnt <= 0;
        end else if (lifo_push && lcnt < DEPTH) begin
            lmem[lcnt] <= lifo_din;
            lcnt       <= lcnt + 1;
        end else if (lifo_pop && lcnt > 0) begin
            lout <= lmem[lcnt-1];
            lcnt <= lcnt - 1;
        end
    end
    assign lifo_dout  = lout;
    assign lifo_empty = (lcnt == 0);
    assign lifo_full  = (lcnt == DEPTH);

    // Protocol monitor, active in every scenario outside reset.
    always @(negedge Clk) begin
        if (Rst_n) begin
            checks++;
            if (lifo_push && lifo_pop) begin
                errors++;
                $display("FAIL strobe_exclusive: push=%0b pop=%0b required not both", lifo_push, lifo_pop);
            end
            checks++;
            if (!$onehot0(ack)) begin
                errors++;
                $display("FAIL ack_onehot: ack=%b required at most one bit", ack);
            end
            checks++;
            if ((ack != '0 || lifo_push || lifo_pop) && !busy) begin
                errors++;
                $display("FAIL busy_active: busy=%0b ack=%b push=%0b pop=%0b required busy=1", busy, ack, lifo_push, lifo_pop);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n    = 1'b0;
        req      = '0;
        lifo_clr = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Rst_n    = 1'b1;
        lifo_clr = 1'b0;
        @(negedge Clk);
    endtask

    // One isolated transaction from requester r, starting in an IDLE cycle.
    task automatic single(input int r, input bit p, input logic [DW-1:0] d,
                          input bit e_err, input logic [DW-1:0] e_rd,
                          input int e_lat, input string nm);
        bit            got;
        int            lat;
        int            npush;
        int            npop;
        logic [DW-1:0] din_seen;
        got = 0; lat = 0; npush = 0; npop = 0; din_seen = '0;
        req[r] = 1'b1;
        op[r]  = p;
        wdata[r*DW +: DW] = d;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge Clk);
            if (lifo_push) begin npush++; din_seen = lifo_din; end
            if (lifo_pop) npop++;
            if (ack != '0) begin
                got    = 1;
                lat    = c;
                req[r] = 1'b0;
                chk({nm, "_ack"}, 32'(ack), 32'(1 << r));
                chk({nm, "_err"}, 32'(err), 32'(e_err));
                chk({nm, "_rdata"}, 32'(rdata), 32'(e_rd));
            end
        end
        req[r] = 1'b0;
        chk({nm, "_ack_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(lat), 32'(e_lat));
        chk({nm, "_push_pulses"}, 32'(npush), 32'(p && !e_err));
        chk({nm, "_pop_pulses"}, 32'(npop), 32'(!p && !e_err));
        if (p && !e_err) chk({nm, "_din"}, 32'(din_seen), 32'(d));
        $display("txn %s: r=%0d %s data=%02h lat=%0d err=%0b rdata=%02h",
                 nm, r, p ? "push" : "pop", d, lat, err, rdata);
        @(negedge Clk);
        chk({nm, "_ack_clear"}, 32'(ack), 32'd0);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int            r;
        bit            push;
        logic [DW-1:0] data;
        bit            e_err;
        logic [DW-1:0] e_rd;
        int            e_lat;
    } vec_t;

    vec_t vecs[8];

    // Random-phase reference state.
    logic [DW-1:0] stk[$];
    int            m_last;
    bit            m_active;
    int            g_cyc, g_lat, g_win;
    bit            g_push, g_rej;
    logic [DW-1:0] g_data, g_rd, m_rdata;

    initial begin
        logic [DW-1:0] pop_exp [4];
        int            grants [4];
        int            ng;
        int            dropped;
        int            bias;
        bit            got;

        vecs[0] = '{0, 1'b0, 8'h00, 1'b1, 8'h00, 1}; // pop on empty
        vecs[1] = '{0, 1'b1, 8'hA5, 1'b0, 8'h00, 2};
        vecs[2] = '{0, 1'b0, 8'h00, 1'b0, 8'hA5, 3};
        vecs[3] = '{1, 1'b0, 8'h00, 1'b1, 8'hA5, 1}; // empty again, rdata held
        vecs[4] = '{1, 1'b1, 8'h3C, 1'b0, 8'hA5, 2};
        vecs[5] = '{0, 1'b1, 8'hC3, 1'b0, 8'hA5, 2};
        vecs[6] = '{1, 1'b0, 8'h00, 1'b0, 8'hC3, 3};
        vecs[7] = '{0, 1'b0, 8'h00, 1'b0, 8'h3C, 3};

        do_reset();
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_push", 32'(lifo_push), 32'd0);
        chk("reset_pop", 32'(lifo_pop), 32'd0);
        chk("reset_din", 32'(lifo_din), 32'd0);

        for (int i = 0; i < 8; i++)
            single(vecs[i].r, vecs[i].push, vecs[i].data, vecs[i].e_err,
                   vecs[i].e_rd, vecs[i].e_lat, $sformatf("vec%0d", i));

        // Contention: both requesters push continuously.
        do_reset();
`ifdef LIFO_ARB_FIXED_PRIO_EN
        pop_exp = '{8'h11, 8'h11, 8'h11, 8'h11};
        grants  = '{0, 0, 0, 0};
`else
        pop_exp = '{8'h22, 8'h11, 8'h22, 8'h11};
        grants  = '{0, 1, 0, 1};
`endif
        op = 2'b11;
        wdata = {8'h22, 8'h11};
        req = 2'b11;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge Clk);
            dropped = -1;
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    chk($sformatf("contend_grant%0d", ng), 32'(i), 32'(grants[ng]));
                    $display("txn contend: grant %0d to r=%0d", ng, i);
                    req[i] = 1'b0;
                    dropped = i;
                    ng++;
                end
            end
            if (ng >= 4) req = '0;
            else for (int i = 0; i < NR; i++) if (i != dropped) req[i] = 1'b1;
        end
        req = '0;
        chk("contend_grants_done", 32'(ng), 32'd4);
        @(negedge Clk);
        for (int i = 0; i < 4; i++)
            single(0, 1'b0, 8'h00, 1'b0, pop_exp[i], 3, $sformatf("contend_pop%0d", i));

        // Full: 16 pushes fill the stack, the 17th is rejected.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            single(i % NR, 1'b1, 8'h80 + 8'(i), 1'b0, 8'h00, 2, $sformatf("fill%0d", i));
        single(0, 1'b1, 8'h77, 1'b1, 8'h00, 1, "push_full");
        single(1, 1'b0, 8'h00, 1'b0, 8'h8F, 3, "pop_after_full");

        // Reset asserted during WAIT of a pop.
        req[0] = 1'b1; op[0] = 1'b0;
        @(negedge Clk);
        chk("rst_mid_issue_pop", 32'(lifo_pop), 32'd1);
        @(negedge Clk);
        chk("rst_mid_wait_busy", 32'(busy), 32'd1);
        req = '0;
        Rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {ack, err, busy, lifo_push, lifo_pop}, 32'd0);
        chk("rst_mid_rdata", 32'(rdata), 32'd0);
        chk("rst_mid_din", 32'(lifo_din), 32'd0);
        @(negedge Clk);
        chk("rst_mid_no_ack", 32'(ack), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_release_busy", 32'(busy), 32'd0);
        chk("rst_release_ack", 32'(ack), 32'd0);
        op = 2'b11; wdata = {8'h44, 8'h33}; req = 2'b11;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge Clk);
            if (ack != '0) begin
                got = 1;
                chk("rst_release_prio", 32'(ack), 32'd1);
                req = '0;
            end
        end
        req = '0;
        chk("rst_release_ack_seen", 32'(got), 32'd1);
        @(negedge Clk);

        // Randomized phase against the transaction-level reference.
        do_reset();
        stk.delete();
        m_last = NR - 1;
        m_active = 0;
        m_rdata = '0;
        g_cyc = 0; g_lat = 0; g_win = 0; g_push = 0; g_rej = 0; g_data = '0; g_rd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit            in_flight, e_ack_cyc, e_push, e_pop, e_busy;
            @(negedge Clk);
            bias      = (cyc < 1500) ? 3 : 1;
            in_flight = m_active && cyc <= g_cyc + g_lat;
            e_busy    = m_active && cyc > g_cyc && cyc <= g_cyc + g_lat;
            e_ack_cyc = m_active && cyc == g_cyc + g_lat;
            e_push    = m_active && cyc == g_cyc + 1 && !g_rej && g_push;
            e_pop     = m_active && cyc == g_cyc + 1 && !g_rej && !g_push;
            if (e_ack_cyc && !g_rej && !g_push) m_rdata = g_rd;
            chk($sformatf("rnd%0d_ack", cyc), 32'(ack), e_ack_cyc ? 32'(1 << g_win) : 32'd0);
            chk($sformatf("rnd%0d_err", cyc), 32'(err), 32'(e_ack_cyc && g_rej));
            chk($sformatf("rnd%0d_busy", cyc), 32'(busy), 32'(e_busy));
            chk($sformatf("rnd%0d_push", cyc), 32'(lifo_push), 32'(e_push));
            chk($sformatf("rnd%0d_pop", cyc), 32'(lifo_pop), 32'(e_pop));
            chk($sformatf("rnd%0d_rdata", cyc), 32'(rdata), 32'(m_rdata));
            if (e_push) chk($sformatf("rnd%0d_din", cyc), 32'(lifo_din), 32'(g_data));
            dropped = -1;
            if (e_ack_cyc) begin
                req[g_win] = 1'b0;
                dropped = g_win;
                $display("txn rnd: cycle=%0d r=%0d %s data=%02h err=%0b depth=%0d",
                         cyc, g_win, g_push ? "push" : "pop", g_push ? g_data : g_rd, g_rej, stk.size());
            end
            for (int i = 0; i < NR; i++) begin
                if (i != dropped && !req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    op[i]  = ($urandom_range(0, 3) < bias);
                    wdata[i*DW +: DW] = DW'($urandom);
                end else if (req[i] && in_flight && i == g_win && !e_ack_cyc) begin
                    wdata[i*DW +: DW] = DW'($urandom); // must not leak into the latched word
                end
            end
            if ((!m_active || cyc > g_cyc + g_lat) && req != '0) begin
                g_win = -1;
`ifdef LIFO_ARB_FIXED_PRIO_EN
                for (int i = NR - 1; i >= 0; i--) if (req[i]) g_win = i;
`else
                for (int k = 1; k <= NR; k++)
                    if (g_win < 0 && req[(m_last + k) % NR]) g_win = (m_last + k) % NR;
`endif
                m_last   = g_win;
                g_push   = op[g_win];
                g_data   = wdata[g_win*DW +: DW];
                g_rej    = g_push ? (stk.size() == DEPTH) : (stk.size() == 0);
                g_lat    = g_rej ? 1 : (g_push ? 2 : 3);
                if (!g_rej && g_push) stk.push_back(g_data);
                if (!g_rej && !g_push) g_rd = stk.pop_back();
                g_cyc    = cyc;
                m_active = 1;
            end
        end
        req = '0;
        @(negedge Clk);
        @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lifo_access_arbiter.md
# lifo_access_arbiter

Sequencing front-end that shares one LIFO memory instance between `NUM_REQ` requesters. It arbitrates round-robin and issues single-cycle PUSH/POP pulses to the LIFO. It returns popped data with a per-requester acknowledge and rejects pushes to a full stack or pops from an empty one without touching the LIFO. It sits between client logic and the LIFO's PUSH/POP/dataIn/dataOut/EMPTY/FULL pins.

## Interface
- `DATA_WIDTH`, 8, word width; must match the attached LIFO.
- `NUM_REQ`, 2, number of requesters (2..8).
- `Clk` input 1: single clock, rising edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `req` input NUM_REQ: per-requester request, held high until its `ack`.
- `op` input NUM_REQ: per-requester operation, 1 = push, 0 = pop; stable while `req` high.
- `wdata` input NUM_REQ*DATA_WIDTH: push data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack` output NUM_REQ: one-cycle completion pulse, one-hot.
- `err` output 1: valid with `ack`; 1 = rejected (push on full or pop on empty).
- `rdata` output DATA_WIDTH: popped word, valid with `ack` for a successful pop, otherwise holds its last value.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `lifo_push` output 1: to LIFO PUSH, registered one-cycle pulse.
- `lifo_pop` output 1: to LIFO POP, registered one-cycle pulse.
- `lifo_din` output DATA_WIDTH: to LIFO dataIn, registered.
- `lifo_dout` input DATA_WIDTH: from LIFO dataOut, registered inside the LIFO and valid the cycle after the POP edge.
- `lifo_empty` input 1: LIFO EMPTY status.
- `lifo_full` input 1: LIFO FULL status.

## Operation
- FSM states:
  - IDLE: if any `req` is high, select the winner and check status. A push with `lifo_full` or a pop with `lifo_empty` goes to RESP with err=1. Otherwise register `lifo_push`/`lifo_pop` and `lifo_din`, then go to ISSUE.
  - ISSUE (1 cycle): strobe is high. Push goes to RESP. Pop goes to WAIT.
  - WAIT (1 cycle): sample `lifo_dout` into `rdata` at the end of this cycle, then go to RESP.
  - RESP (1 cycle): `ack[winner]`=1 and `err` is valid. Always go to IDLE.
- One transaction in flight at a time. The block does not pipeline across transactions.
- Round-robin: search starts at index (last_grant+1) mod NUM_REQ. `last_grant` updates on every grant, including rejected ones. After reset, `last_grant` = NUM_REQ-1, so requester 0 has first priority.
- The winner index, op and data are latched at grant. Later changes on `req`/`op`/`wdata` do not affect the transaction in flight.
- Requesters must deassert `req` by the edge that ends their `ack` cycle. A `req` still high in IDLE is a new request.
- `lifo_push` and `lifo_pop` are never high together and never high outside ISSUE.
- Reset (any time, including mid-transaction): state = IDLE and the in-flight transaction is dropped with no `ack`. Reset values: `ack`=0, `err`=0, `rdata`=0, `busy`=0, `lifo_push`=0, `lifo_pop`=0, `lifo_din`=0, `last_grant`=NUM_REQ-1. The LIFO's own reset is external to this block.

## Timing
- Cycle 0 is the cycle in which IDLE sees `req` (the request is accepted at the end of cycle 0).
- Successful push: strobe in cycle 1, `ack` in cycle 2. Latency is 2.
- Successful pop: strobe in cycle 1, `rdata` valid and `ack` in cycle 3. Latency is 3.
- Rejected request: `ack` with err=1 in cycle 1. Latency is 1.
- Back-to-back: the next grant is evaluated in the cycle after RESP. The minimum request-to-request period is 3 (push), 4 (pop) or 2 (reject).
- Status flags are sampled only in IDLE. Because only this block drives the LIFO, the flags are stable by the next IDLE.

## Configuration
- `LIFO_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest index wins. `last_grant` is not implemented.
  - Undefined (default): round-robin as described above.
- Timing and handshake are identical in both modes.

## Test plan
- Single push/pop, NUM_REQ=2, DEPTH=16:
  - req[0] pushes 0xA5: `lifo_push` in cycle 1, `lifo_din`=0xA5, ack[0] in cycle 2, err=0.
  - req[0] then pops: `rdata`=0xA5 and ack[0] in cycle 3.
- Contention: req[0] and req[1] both push continuously, with 0x11 and 0x22 respectively.
  - Grants alternate 0,1,0,1.
  - A following pop sequence returns 0x22,0x11,0x22,0x11.
  - With `LIFO_ARB_FIXED_PRIO_EN` defined, requester 0 is always granted while its `req` is high.
- Empty: pop with `lifo_empty`=1 gives ack in cycle 1, err=1, no `lifo_pop` pulse, `rdata` unchanged.
- Full: 16 pushes then a 17th push with 0x77 gives err=1 and no `lifo_push`. The next pop returns the 16th pushed value.
- Reset mid-op: deassert `Rst_n` during WAIT of a pop. All outputs go to 0 asynchronously, no `ack` is issued, and after release `busy`=0 and requester 0 holds priority.
- Protocol: `lifo_push`&`lifo_pop` is never 1, `ack` is one-hot, and `busy` is low only in IDLE. All three are checked by assertion in every scenario.
